// File: rtl/vga_pkg.sv
// Shared VGA stream definitions.
// Holds the counter/colour widths used across the video pipeline, the timing
// bundle carried alongside each pixel, and the obstacle overlay defaults.
package vga_pkg;

  localparam int unsigned HCOUNT_W = 11;
  localparam int unsigned VCOUNT_W = 11;
  localparam int unsigned RGB_W    = 12;
  localparam int unsigned POS_W    = 12;

  // Obstacle overlay defaults
  localparam int unsigned      OBS_W_DEF       = 40;
  localparam int unsigned      OBS_H_DEF       = 30;
  localparam logic [RGB_W-1:0] OBS_COLOR_DEF   = 12'h0F0;
  localparam logic [POS_W-1:0] OBS_X_OFFSCREEN = 12'hFFF;

  // Timing signals that travel with every pixel through the pipeline
  typedef struct packed {
    logic [HCOUNT_W-1:0] hcount;
    logic                hsync;
    logic                hblnk;
    logic [VCOUNT_W-1:0] vcount;
    logic                vsync;
    logic                vblnk;
  } vga_timing_t;

endpackage

// File: rtl/rect_hit.sv
// Combinational rectangle bounds test.
// Ports:
//   hcount, vcount : current pixel coordinates
//   x, y           : top-left corner of the rectangle
//   hit            : pixel lies inside [x, x+W) x [y, y+H)
// Bounds are evaluated at 13 bits so a corner near 12'hFFF cannot wrap
// around into the visible area.
module rect_hit
  import vga_pkg::*;
#(
  parameter int unsigned W = OBS_W_DEF,
  parameter int unsigned H = OBS_H_DEF
) (
  input  logic [HCOUNT_W-1:0] hcount,
  input  logic [VCOUNT_W-1:0] vcount,
  input  logic [POS_W-1:0]    x,
  input  logic [POS_W-1:0]    y,
  output logic                hit
);

  localparam logic [12:0] W13 = 13'(W);
  localparam logic [12:0] H13 = 13'(H);

  logic [12:0] h13, v13, x13, y13;

  always_comb begin
    h13 = 13'(hcount);
    v13 = 13'(vcount);
    x13 = 13'(x);
    y13 = 13'(y);
    hit = (h13 >= x13) && (h13 < x13 + W13) && (v13 >= y13) && (v13 < y13 + H13);
  end

endmodule

// File: rtl/draw_obstacle.sv
// Obstacle overlay and player collision detector for the VGA pixel stream.
// Ports:
//   clk, rst                      : pixel clock, synchronous active-high reset
//   *count_in, *sync_in, *blnk_in : upstream timing
//   rgb_in, player_on_in          : upstream colour and player-rect membership
//   obs_xpos, obs_ypos_1/2        : obstacle positions (latched at vblank onset)
//   *_out                         : timing and colour delayed by 2 clk
//   collision                     : one-clk pulse at vblank onset if the player
//                                   touched an obstacle during the ending frame
module draw_obstacle
  import vga_pkg::*;
#(
  parameter int unsigned      OBS_W     = OBS_W_DEF,
  parameter int unsigned      OBS_H     = OBS_H_DEF,
  parameter logic [RGB_W-1:0] OBS_COLOR = OBS_COLOR_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [HCOUNT_W-1:0] hcount_in,
  input  logic                hsync_in,
  input  logic                hblnk_in,
  input  logic [VCOUNT_W-1:0] vcount_in,
  input  logic                vsync_in,
  input  logic                vblnk_in,
  input  logic [RGB_W-1:0]    rgb_in,
  input  logic                player_on_in,
  input  logic [POS_W-1:0]    obs_xpos,
  input  logic [POS_W-1:0]    obs_ypos_1,
  input  logic [POS_W-1:0]    obs_ypos_2,
  output logic [HCOUNT_W-1:0] hcount_out,
  output logic                hsync_out,
  output logic                hblnk_out,
  output logic [VCOUNT_W-1:0] vcount_out,
  output logic                vsync_out,
  output logic                vblnk_out,
  output logic [RGB_W-1:0]    rgb_out,
  output logic                collision
);

  // Frame-latched obstacle positions
  logic [POS_W-1:0] shadow_x, shadow_y1, shadow_y2;

  vga_timing_t      tim_in, tim_d1, tim_d2;
  logic [RGB_W-1:0] rgb_d1;
  logic             player_on_d1;
  logic             hit_1, hit_2, hit_d1;
  logic             hit_flag;

  logic             frame_end;
  logic             col_set;
  logic             draw_d1;

  assign tim_in = '{hcount: hcount_in, hsync: hsync_in, hblnk: hblnk_in,
                    vcount: vcount_in, vsync: vsync_in, vblnk: vblnk_in};

  rect_hit #(.W(OBS_W), .H(OBS_H)) u_hit_1 (
    .hcount (hcount_in),
    .vcount (vcount_in),
    .x      (shadow_x),
    .y      (shadow_y1),
    .hit    (hit_1)
  );

  rect_hit #(.W(OBS_W), .H(OBS_H)) u_hit_2 (
    .hcount (hcount_in),
    .vcount (vcount_in),
    .x      (shadow_x),
    .y      (shadow_y2),
    .hit    (hit_2)
  );

  always_comb begin
    // tim_d1.vblnk doubles as the vblank edge-detect delay
    frame_end = vblnk_in & ~tim_d1.vblnk;
    draw_d1   = hit_d1 & ~tim_d1.hblnk & ~tim_d1.vblnk;
    col_set   = draw_d1 & player_on_d1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_x     <= OBS_X_OFFSCREEN;
      shadow_y1    <= '0;
      shadow_y2    <= '0;
      tim_d1       <= '0;
      tim_d2       <= '0;
      rgb_d1       <= '0;
      player_on_d1 <= 1'b0;
      hit_d1       <= 1'b0;
      rgb_out      <= '0;
      hit_flag     <= 1'b0;
      collision    <= 1'b0;
    end else begin
      // Stage 1
      tim_d1       <= tim_in;
      rgb_d1       <= rgb_in;
      player_on_d1 <= player_on_in;
      hit_d1       <= hit_1 | hit_2;
      // Stage 2
      tim_d2       <= tim_d1;
      rgb_out      <= draw_d1 ? OBS_COLOR : rgb_d1;

      if (frame_end) begin
        shadow_x  <= obs_xpos;
        shadow_y1 <= obs_ypos_1;
        shadow_y2 <= obs_ypos_2;
        // A hit landing on the same edge still belongs to the ending frame
        collision <= hit_flag | col_set;
        hit_flag  <= 1'b0;
      end else begin
        collision <= 1'b0;
        hit_flag  <= hit_flag | col_set;
      end
    end
  end

  assign hcount_out = tim_d2.hcount;
  assign hsync_out  = tim_d2.hsync;
  assign hblnk_out  = tim_d2.hblnk;
  assign vcount_out = tim_d2.vcount;
  assign vsync_out  = tim_d2.vsync;
  assign vblnk_out  = tim_d2.vblnk;

endmodule

// File: tb/tb_draw_obstacle.sv
// Directed bench for draw_obstacle: passthrough, frame-latched drawing,
// collision pulse, blanking, reset and off-screen x.
module tb_draw_obstacle;

  localparam logic [11:0] OBS_COL = 12'h0F0;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] hcount_in, vcount_in;
  logic        hsync_in, hblnk_in, vsync_in, vblnk_in;
  logic [11:0] rgb_in;
  logic        player_on_in;
  logic [11:0] obs_xpos, obs_ypos_1, obs_ypos_2;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, hblnk_out, vsync_out, vblnk_out;
  logic [11:0] rgb_out;
  logic        collision;

  int checks = 0;
  int errors = 0;
  int pulses;
  logic first;

  always #5 clk = ~clk;

  draw_obstacle dut (
    .clk          (clk),
    .rst          (rst),
    .hcount_in    (hcount_in),
    .hsync_in     (hsync_in),
    .hblnk_in     (hblnk_in),
    .vcount_in    (vcount_in),
    .vsync_in     (vsync_in),
    .vblnk_in     (vblnk_in),
    .rgb_in       (rgb_in),
    .player_on_in (player_on_in),
    .obs_xpos     (obs_xpos),
    .obs_ypos_1   (obs_ypos_1),
    .obs_ypos_2   (obs_ypos_2),
    .hcount_out   (hcount_out),
    .hsync_out    (hsync_out),
    .hblnk_out    (hblnk_out),
    .vcount_out   (vcount_out),
    .vsync_out    (vsync_out),
    .vblnk_out    (vblnk_out),
    .rgb_out      (rgb_out),
    .collision    (collision)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Sync outputs follow an arbitrary pattern of the counters so their delay is checked too
  task automatic drive(input logic [10:0] h, input logic [10:0] v, input logic hb,
                       input logic vb, input logic pl, input logic [11:0] rgb);
    hcount_in    = h;
    vcount_in    = v;
    hsync_in     = h[3];
    vsync_in     = v[1];
    hblnk_in     = hb;
    vblnk_in     = vb;
    player_on_in = pl;
    rgb_in       = rgb;
  endtask

  // Hold one pixel for two clocks, then check the overlaid colour and delayed timing
  task automatic pix(input string tag, input logic [10:0] h, input logic [10:0] v,
                     input logic hb, input logic pl, input logic [11:0] rgb,
                     input logic [11:0] exp_rgb);
    logic [25:0] exp_tim;
    drive(h, v, hb, 1'b0, pl, rgb);
    tick;
    tick;
    exp_tim = {h, h[3], hb, v, v[1], 1'b0};
    chk({tag, " rgb"}, 32'(rgb_out), 32'(exp_rgb));
    chk({tag, " timing"}, 32'({hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out,
                              vblnk_out}), 32'(exp_tim));
  endtask

  // Blank filler, then a vblank onset; count collision pulses over the next few clocks
  task automatic frame_end(output int n, output logic first_clk);
    drive(11'd0, 11'd599, 1'b1, 1'b0, 1'b0, 12'h000);
    tick;
    tick;
    drive(11'd0, 11'd600, 1'b1, 1'b1, 1'b0, 12'h000);
    tick;
    first_clk = collision;
    n = int'(collision);
    for (int i = 0; i < 4; i++) begin
      tick;
      n += int'(collision);
    end
  endtask

  initial begin
    rst        = 1'b1;
    obs_xpos   = 12'hFFF;
    obs_ypos_1 = 12'h000;
    obs_ypos_2 = 12'h000;
    drive(11'd5, 11'd7, 1'b1, 1'b1, 1'b1, 12'hABC);
    tick;
    tick;
    chk("reset rgb", 32'(rgb_out), 32'h0);
    chk("reset timing", 32'({hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out,
                             vblnk_out}), 32'h0);
    chk("reset collision", 32'(collision), 32'h0);
    rst = 1'b0;

    // 1) Off-screen obstacle: passthrough and no collision
    pix("t1 p0", 11'd100, 11'd250, 1'b0, 1'b1, 12'h123, 12'h123);
    pix("t1 p1", 11'd0, 11'd0, 1'b0, 1'b1, 12'hFED, 12'hFED);
    frame_end(pulses, first);
    chk("t1 frame1 pulses", 32'(pulses), 32'd0);
    pix("t1 p2", 11'd799, 11'd599, 1'b0, 1'b1, 12'h456, 12'h456);
    frame_end(pulses, first);
    chk("t1 frame2 pulses", 32'(pulses), 32'd0);

    // Exact 2-clk latency with changing inputs every clock
    drive(11'd10, 11'd20, 1'b0, 1'b0, 1'b0, 12'h111);
    tick;
    drive(11'd11, 11'd21, 1'b0, 1'b0, 1'b0, 12'h222);
    tick;
    drive(11'd12, 11'd22, 1'b0, 1'b0, 1'b0, 12'h333);
    chk("latency hcount a", 32'(hcount_out), 32'd10);
    chk("latency rgb a", 32'(rgb_out), 32'h111);
    tick;
    chk("latency vcount b", 32'(vcount_out), 32'd21);
    chk("latency rgb b", 32'(rgb_out), 32'h222);

    // 2) New positions take effect only after the next vblank onset
    obs_xpos   = 12'd100;
    obs_ypos_1 = 12'd250;
    obs_ypos_2 = 12'd440;
    pix("t2 midframe", 11'd100, 11'd250, 1'b0, 1'b0, 12'h321, 12'h321);
    frame_end(pulses, first);
    chk("t2 no pulse", 32'(pulses), 32'd0);
    pix("t2 tl1", 11'd100, 11'd250, 1'b0, 1'b0, 12'h321, OBS_COL);
    pix("t2 br1", 11'd139, 11'd279, 1'b0, 1'b0, 12'h322, OBS_COL);
    pix("t2 right", 11'd140, 11'd250, 1'b0, 1'b0, 12'h323, 12'h323);
    pix("t2 below", 11'd100, 11'd280, 1'b0, 1'b0, 12'h324, 12'h324);
    pix("t2 left", 11'd99, 11'd260, 1'b0, 1'b0, 12'h325, 12'h325);
    pix("t2 tl2", 11'd100, 11'd440, 1'b0, 1'b0, 12'h326, OBS_COL);
    pix("t2 br2", 11'd139, 11'd469, 1'b0, 1'b0, 12'h327, OBS_COL);
    pix("t2 below2", 11'd139, 11'd470, 1'b0, 1'b0, 12'h328, 12'h328);
    frame_end(pulses, first);
    chk("t2 no player pulse", 32'(pulses), 32'd0);

    // 3) Player overlaps obstacle: one pulse at the next onset, none after
    pix("t3 hit", 11'd110, 11'd260, 1'b0, 1'b1, 12'h777, OBS_COL);
    frame_end(pulses, first);
    chk("t3 pulse count", 32'(pulses), 32'd1);
    chk("t3 pulse first clk", 32'(first), 32'd1);
    frame_end(pulses, first);
    chk("t3 next frame pulses", 32'(pulses), 32'd0);

    // 4) Overlap only during hblank: no drawing, no collision
    pix("t4 hblnk", 11'd110, 11'd260, 1'b1, 1'b1, 12'h888, 12'h888);
    frame_end(pulses, first);
    chk("t4 pulses", 32'(pulses), 32'd0);

    // 6) Reset mid-frame after a hit
    pix("t6 hit", 11'd110, 11'd260, 1'b0, 1'b1, 12'h999, OBS_COL);
    drive(11'd110, 11'd300, 1'b0, 1'b0, 1'b0, 12'h999);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("t6 rst rgb", 32'(rgb_out), 32'h0);
    chk("t6 rst hcount", 32'(hcount_out), 32'h0);
    chk("t6 rst collision", 32'(collision), 32'h0);
    pix("t6 not drawn", 11'd110, 11'd260, 1'b0, 1'b0, 12'h5A5, 12'h5A5);
    frame_end(pulses, first);
    chk("t6 pulses", 32'(pulses), 32'd0);
    pix("t6 reloaded", 11'd110, 11'd260, 1'b0, 1'b0, 12'h5A5, OBS_COL);

    // 5) x near 12'hFFF never wraps into view
    obs_xpos = 12'd4090;
    frame_end(pulses, first);
    pix("t5 h0", 11'd0, 11'd250, 1'b0, 1'b1, 12'h246, 12'h246);
    pix("t5 h30", 11'd30, 11'd260, 1'b0, 1'b1, 12'h247, 12'h247);
    pix("t5 h2047", 11'd2047, 11'd440, 1'b0, 1'b1, 12'h248, 12'h248);
    frame_end(pulses, first);
    chk("t5 pulses", 32'(pulses), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
